// File: rtl/mod_counter_pkg.sv
// Shared definitions for the VDG timing-chain counters: FSM state encoding and mode constants.
package mod_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic MODE_FREE    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mod_counter_count_compare.sv
// One registered equality-compare channel, fed from the counter's next-count so the
// match flag lines up with the count it describes.
module count_compare #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_d_i,
   input  logic [WIDTH-1:0] cmp_value_i,
   output logic             match_o
);

   logic match_q;

   always_ff @(negedge clk or posedge reset) begin
      if (reset) match_q <= 1'b0;
      else       match_q <= (count_d_i == cmp_value_i);
   end

   assign match_o = match_q;

endmodule

// File: rtl/mod_counter.sv
// Modulo counter for the VDG timing chain: runtime limit, up/down, load, free-run or
// one-shot, cascade carry and NUM_CMP compare channels. State changes on negedge clk.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | stopped after reset/clear, waiting for start
//   ST_RUN  | counting on enabled edges
//   ST_DONE | one-shot reached terminal, count held until start
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_CMP = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     load,
   input  logic [WIDTH-1:0]         load_value,
   input  logic                     start,
   input  logic                     up,
   input  logic                     mode,
   input  logic [WIDTH-1:0]         limit,
   input  logic [NUM_CMP*WIDTH-1:0] cmp_value,
   output logic [WIDTH-1:0]         count,
   output logic                     carry_out,
   output logic                     tc,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_CMP-1:0]       cmp_match
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] start_val;
   logic             at_term;

   assign start_val = up ? '0 : limit;
   // >= rather than == so a limit lowered below the current count still terminates
   assign at_term   = up ? (count_q >= limit) : (count_q == '0);
   assign carry_out = (state_q == ST_RUN) && enable && at_term;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (load) begin
         count_d = load_value;
      end else if (start && (state_q != ST_RUN)) begin
         state_d = ST_RUN;
         count_d = start_val;
      end else if ((state_q == ST_RUN) && enable) begin
         if (at_term) begin
            tc_d = 1'b1;
            if (mode == MODE_ONESHOT) state_d = ST_DONE;
            else                      count_d = start_val;
         end else if (up) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
      count_compare #(.WIDTH(WIDTH)) u_cmp (
         .clk         (clk),
         .reset       (reset),
         .count_d_i   (count_d),
         .cmp_value_i (cmp_value[i*WIDTH +: WIDTH]),
         .match_o     (cmp_match[i])
      );
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);

endmodule
